// File: rtl/game_sequencer.sv
// Frame-paced Space Race sequencer: coin debounce, credit bookkeeping, game start,
// play timer and game-over hold. All timing advances on the per-frame tick.
module game_sequencer #(
  parameter int MAX_CREDITS = 9,
  parameter int BASE_FRAMES = 2700,
  parameter int EXT_FRAMES  = 270,
  parameter int OVER_FRAMES = 120,
  parameter int TW          = 13
) (
  input  logic          CLOCK,
  input  logic          RESET_N,
  input  logic          FRAME_TICK,
  input  logic          COIN_SW,
  input  logic          START_GAME,
  input  logic          COINAGE,
  input  logic [3:0]    PLAYTIME,
  output logic          GAME_ON,
  output logic          RESET_SCORE_N,
  output logic          CREDIT_LIGHT_N,
  output logic [3:0]    CREDITS,
  output logic [TW-1:0] TIME_LEFT
);

  localparam int HW = $clog2(OVER_FRAMES + 1);

  typedef enum logic [1:0] {ATTRACT, START, PLAY, OVER} state_t;

  state_t        state;
  logic [1:0]    coin_sh;
  logic          start_q;
  logic [3:0]    credits;
  logic [TW-1:0] timer;
  logic [HW-1:0] hold;

  logic          coin_accept;
  logic          start_strobe;
  logic          start_ok;
  logic [4:0]    credit_sum;
  logic [3:0]    credits_next;
  logic [3:0]    pt_clamp;
  logic [TW-1:0] timer_load;

  // Start eligibility uses the registered credit count, before this cycle's coin.
  always_comb begin
    coin_accept  = FRAME_TICK && coin_sh[0] && COIN_SW && (coin_sh != 2'b11);
    start_strobe = START_GAME && !start_q;
    start_ok     = start_strobe && (credits != 4'd0) && (state == ATTRACT || state == OVER);
    credit_sum   = {1'b0, credits}
                 + (coin_accept ? (COINAGE ? 5'd2 : 5'd1) : 5'd0)
                 - (start_ok ? 5'd1 : 5'd0);
    credits_next = (credit_sum > 5'(MAX_CREDITS)) ? 4'(MAX_CREDITS) : credit_sum[3:0];
    pt_clamp     = (PLAYTIME > 4'd10) ? 4'd10 : PLAYTIME;
    timer_load   = TW'(BASE_FRAMES + int'(pt_clamp) * EXT_FRAMES);
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state          <= ATTRACT;
      coin_sh        <= 2'b00;
      start_q        <= 1'b0;
      credits        <= 4'd0;
      timer          <= '0;
      hold           <= '0;
      GAME_ON        <= 1'b0;
      RESET_SCORE_N  <= 1'b1;
      CREDIT_LIGHT_N <= 1'b1;
    end else begin
      start_q <= START_GAME;
      credits <= credits_next;
      if (FRAME_TICK)
        coin_sh <= {coin_sh[0], COIN_SW};

      // A start wins over a coincident frame tick: the timer loads, no decrement.
      if (start_ok) begin
        state          <= START;
        timer          <= timer_load;
        GAME_ON        <= 1'b1;
        RESET_SCORE_N  <= 1'b0;
        CREDIT_LIGHT_N <= 1'b1;
      end else begin
        case (state)
          ATTRACT: begin
            CREDIT_LIGHT_N <= (credits_next == 4'd0);
          end
          START: begin
            CREDIT_LIGHT_N <= 1'b1;
            if (FRAME_TICK) begin
              state         <= PLAY;
              RESET_SCORE_N <= 1'b1;
            end
          end
          PLAY: begin
            if (FRAME_TICK && timer <= TW'(1)) begin
              state          <= OVER;
              timer          <= '0;
              hold           <= HW'(OVER_FRAMES);
              GAME_ON        <= 1'b0;
              CREDIT_LIGHT_N <= (credits_next == 4'd0);
            end else begin
              CREDIT_LIGHT_N <= 1'b1;
              if (FRAME_TICK)
                timer <= timer - 1'b1;
            end
          end
          OVER: begin
            CREDIT_LIGHT_N <= (credits_next == 4'd0);
            if (FRAME_TICK) begin
              if (hold <= HW'(1)) begin
                state <= ATTRACT;
                hold  <= '0;
              end else begin
                hold <= hold - 1'b1;
              end
            end
          end
          default: state <= ATTRACT;
        endcase
      end
    end
  end

  assign CREDITS   = credits;
  assign TIME_LEFT = timer;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer with shortened timing (base 20, ext 2, over 5).
module tb_game_sequencer;

  localparam int TW = 13;

  logic          clock;
  logic          reset_n;
  logic          frame_tick;
  logic          coin_sw;
  logic          start_game;
  logic          coinage;
  logic [3:0]    playtime;
  logic          game_on;
  logic          reset_score_n;
  logic          credit_light_n;
  logic [3:0]    credits;
  logic [TW-1:0] time_left;

  game_sequencer #(
    .MAX_CREDITS(9),
    .BASE_FRAMES(20),
    .EXT_FRAMES (2),
    .OVER_FRAMES(5),
    .TW         (TW)
  ) dut (
    .CLOCK         (clock),
    .RESET_N       (reset_n),
    .FRAME_TICK    (frame_tick),
    .COIN_SW       (coin_sw),
    .START_GAME    (start_game),
    .COINAGE       (coinage),
    .PLAYTIME      (playtime),
    .GAME_ON       (game_on),
    .RESET_SCORE_N (reset_score_n),
    .CREDIT_LIGHT_N(credit_light_n),
    .CREDITS       (credits),
    .TIME_LEFT     (time_left)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int cr;
    int gon;
    int rsn;
    int cln;
    int tl;
  } exp_t;

  exp_t  sb[$];
  string tag_q[$];

  int checks   = 0;
  int failures = 0;

  int e_cr, e_gon, e_rsn, e_cln, e_tl;
  bit in_play;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic tick, input logic coin, input logic start);
    frame_tick = tick;
    coin_sw    = coin;
    start_game = start;
  endtask

  task automatic pushExpect(input string tag);
    exp_t e;
    e.cr  = e_cr;
    e.gon = e_gon;
    e.rsn = e_rsn;
    e.cln = e_cln;
    e.tl  = e_tl;
    sb.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compareNow();
    exp_t  e;
    string t;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      t = tag_q.pop_front();
      checkOutput({t, ".credits"},        int'(credits),        e.cr);
      checkOutput({t, ".game_on"},        int'(game_on),        e.gon);
      checkOutput({t, ".reset_score_n"},  int'(reset_score_n),  e.rsn);
      checkOutput({t, ".credit_light_n"}, int'(credit_light_n), e.cln);
      checkOutput({t, ".time_left"},      int'(time_left),      e.tl);
    end
  endtask

  task automatic step(input logic tick, input logic coin, input logic start, input string tag);
    applyStimulus(tick, coin, start);
    pushExpect(tag);
    @(posedge clock);
    #1;
    frame_tick = 1'b0;
    compareNow();
  endtask

  task automatic frameTick(input logic coin, input string tag);
    if (in_play)
      e_tl = e_tl - 1;
    step(1'b1, coin, 1'b0, tag);
    // Non-tick cycles between frames keep the coin level; it must not be sampled.
    step(1'b0, coin, 1'b0, {tag, "_gap"});
  endtask

  task automatic insertCoin(input int credits_after, input string tag);
    frameTick(1'b0, {tag, "_low"});
    frameTick(1'b1, {tag, "_high1"});
    e_cr = credits_after;
    if (!in_play)
      e_cln = (credits_after == 0) ? 1 : 0;
    frameTick(1'b1, {tag, "_high2"});
  endtask

  task automatic setResetExpect();
    e_cr    = 0;
    e_gon   = 0;
    e_rsn   = 1;
    e_cln   = 1;
    e_tl    = 0;
    in_play = 1'b0;
  endtask

  task automatic doReset(input string tag);
    reset_n = 1'b0;
    setResetExpect();
    step(1'b0, 1'b0, 1'b0, tag);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int coin_vals[5];
    coin_vals = '{2, 4, 6, 8, 9};

    reset_n  = 1'b0;
    coinage  = 1'b0;
    playtime = 4'd3;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    setResetExpect();
    step(1'b0, 1'b0, 1'b0, "reset");
    reset_n = 1'b1;

    // One credit per coin, then a single-frame glitch and a clock-level glitch.
    step(1'b0, 1'b0, 1'b0, "idle");
    insertCoin(1, "coin1");
    frameTick(1'b0, "glitch_a");
    frameTick(1'b1, "glitch_b");
    frameTick(1'b0, "glitch_c");
    step(1'b0, 1'b1, 1'b0, "clk_glitch1");
    step(1'b0, 1'b1, 1'b0, "clk_glitch2");
    step(1'b0, 1'b1, 1'b0, "clk_glitch3");
    frameTick(1'b0, "clk_glitch_end");

    // Two credits per coin, saturating at nine.
    doReset("reset2");
    coinage = 1'b1;
    for (int i = 0; i < 5; i++)
      insertCoin(coin_vals[i], $sformatf("coin2x_%0d", i));

    // Full game: start coincident with a frame tick, 26 frames of play, game over.
    doReset("reset3");
    coinage = 1'b0;
    insertCoin(1, "coin3");
    playtime = 4'd3;
    e_cr  = 0;
    e_gon = 1;
    e_rsn = 0;
    e_cln = 1;
    e_tl  = 26;
    step(1'b1, 1'b0, 1'b1, "start_tick");
    step(1'b0, 1'b0, 1'b0, "start_hold");
    e_rsn = 1;
    step(1'b1, 1'b0, 1'b0, "to_play");
    step(1'b0, 1'b0, 1'b0, "to_play_gap");
    in_play = 1'b1;
    for (int i = 0; i < 25; i++)
      frameTick(1'b0, $sformatf("play_%0d", i));
    in_play = 1'b0;
    e_tl  = 0;
    e_gon = 0;
    e_cln = 1;
    step(1'b1, 1'b0, 1'b0, "game_end");
    for (int i = 0; i < 5; i++)
      frameTick(1'b0, $sformatf("over_%0d", i));
    step(1'b0, 1'b0, 1'b1, "start_nocredit");
    step(1'b0, 1'b0, 1'b0, "start_nocredit_rel");

    // Clamped play time.
    insertCoin(1, "coin4");
    playtime = 4'd15;
    e_cr  = 0;
    e_gon = 1;
    e_rsn = 0;
    e_cln = 1;
    e_tl  = 40;
    step(1'b0, 1'b0, 1'b1, "start_clamp");
    e_rsn = 1;
    step(1'b1, 1'b0, 1'b0, "to_play2");
    in_play = 1'b1;

    // Coin during play, start ignored during play, restart from game over.
    insertCoin(1, "coin_play");
    step(1'b0, 1'b0, 1'b1, "start_in_play");
    step(1'b0, 1'b0, 1'b0, "start_in_play_rel");
    while (e_tl > 1)
      frameTick(1'b0, "play2");
    in_play = 1'b0;
    e_tl  = 0;
    e_gon = 0;
    e_cln = 0;
    step(1'b1, 1'b0, 1'b0, "game_end2");
    frameTick(1'b0, "over2");
    e_cr  = 0;
    e_gon = 1;
    e_rsn = 0;
    e_cln = 1;
    e_tl  = 40;
    step(1'b0, 1'b0, 1'b1, "restart_over");

    // Asynchronous reset between clock edges in the middle of play.
    e_rsn = 1;
    step(1'b1, 1'b0, 1'b0, "to_play3");
    in_play = 1'b1;
    insertCoin(1, "coin_play3");
    #3;
    reset_n = 1'b0;
    #1;
    setResetExpect();
    pushExpect("async_reset");
    compareNow();
    step(1'b0, 1'b0, 1'b0, "async_reset_hold");
    reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
